wishbone_banked_ram: RTL

Parametrised Wishbone B3 slave memory built from `NUM_BANKS` banks of `BANK_DEPTH` words, each `DATA_WIDTH` bits wide. Writes are byte-lane masked through `sel_i`. The block supports linear incrementing bursts (registered-feedback) at one word per cycle, and raises `err_o` on out-of-range addresses. It sits on the SoC Wishbone bus next to the existing single-bank 8-bit RAM slaves and replaces them wherever a wider or deeper RAM is needed.

---
 rtl/wishbone_banked_ram_if.sv | 29 ++
 rtl/wishbone_banked_ram.sv | 133 +++++++++++++
 2 files changed

// File: rtl/wishbone_banked_ram_if.sv
// Wishbone B3 bus bundle for the banked RAM slave.
// Signal names follow the slave's point of view.
interface wishbone_banked_ram_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int DATA_BYTES    = 4
);
    logic [ADDRESS_WIDTH-1:0] adr_i;
    logic [DATA_WIDTH-1:0]    dat_i;
    logic [DATA_WIDTH-1:0]    dat_o;
    logic                     we_i;
    logic [DATA_BYTES-1:0]    sel_i;
    logic                     stb_i;
    logic                     cyc_i;
    logic [2:0]               cti_i;
    logic [1:0]               bte_i;
    logic                     ack_o;
    logic                     err_o;

    modport master (
        output adr_i, dat_i, we_i, sel_i, stb_i, cyc_i, cti_i, bte_i,
        input  dat_o, ack_o, err_o
    );

    modport slave (
        input  adr_i, dat_i, we_i, sel_i, stb_i, cyc_i, cti_i, bte_i,
        output dat_o, ack_o, err_o
    );
endinterface

// File: rtl/wishbone_banked_ram.sv
// Wishbone B3 slave RAM built from NUM_BANKS contiguous banks with byte-lane writes,
// registered-feedback linear bursts and err_o on out-of-range word addresses.
module wishbone_banked_ram #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int DATA_BYTES    = 4,
    parameter int BASE_ADDRESS  = 0,
    parameter int BANK_DEPTH    = 512,
    parameter int NUM_BANKS     = 2
) (
    input logic                 clk_i,
    input logic                 rst_i,
    wishbone_banked_ram_if.slave wb
);
    localparam int ROW_W  = $clog2(BANK_DEPTH);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int SIZE   = NUM_BANKS * BANK_DEPTH;
    localparam logic [ADDRESS_WIDTH:0]   SIZE_W = (ADDRESS_WIDTH + 1)'(SIZE);
    localparam logic [ADDRESS_WIDTH-1:0] BASE_W = ADDRESS_WIDTH'(BASE_ADDRESS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SINGLE,
        ST_BURST
    } state_t;

    state_t              state_reg;
    logic                ack_reg;
    logic                err_reg;
    logic [BANK_W-1:0]   bank_sel_reg;

    logic                     req;
    logic                     burst_req;
    logic                     burst_go;
    logic                     rd_en;
    logic                     wr_en;
    logic [ADDRESS_WIDTH-1:0] wr_local;
    logic [ADDRESS_WIDTH-1:0] pred_local;
    logic [ADDRESS_WIDTH-1:0] rd_local;
    logic                     wr_valid;
    logic                     rd_valid;
    logic [BANK_W-1:0]        wr_bank;
    logic [BANK_W-1:0]        rd_bank;
    logic [ROW_W-1:0]         wr_row;
    logic [ROW_W-1:0]         rd_row;
    logic [DATA_WIDTH-1:0]    bank_rd_data [NUM_BANKS];

    assign req       = wb.cyc_i & wb.stb_i;
    assign burst_req = (wb.cti_i == 3'b010) && (wb.bte_i == 2'b00);
    assign burst_go  = (state_reg == ST_BURST) && req && (wb.cti_i != 3'b111);

    // Writes always land at the address on the bus; reads in a burst run one word ahead.
    assign wr_local   = wb.adr_i - BASE_W;
    assign pred_local = wb.adr_i + ADDRESS_WIDTH'(1) - BASE_W;
    assign rd_local   = (state_reg == ST_BURST) ? pred_local : wr_local;

    assign wr_valid = {1'b0, wr_local} < SIZE_W;
    assign rd_valid = {1'b0, rd_local} < SIZE_W;
    assign wr_bank  = wr_local[ROW_W +: BANK_W];
    assign rd_bank  = rd_local[ROW_W +: BANK_W];
    assign wr_row   = wr_local[ROW_W-1:0];
    assign rd_row   = rd_local[ROW_W-1:0];

    assign wr_en = req & wb.we_i & wr_valid & ~rst_i;
    assign rd_en = ~rst_i & (((state_reg == ST_IDLE) && req) || burst_go);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= ST_IDLE;
            ack_reg      <= 1'b0;
            err_reg      <= 1'b0;
            bank_sel_reg <= '0;
        end else begin
            ack_reg <= 1'b0;
            err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req) begin
                        state_reg <= burst_req ? ST_BURST : ST_SINGLE;
                        ack_reg   <= rd_valid;
                        err_reg   <= ~rd_valid;
                    end
                end
                ST_SINGLE: begin
                    state_reg <= ST_IDLE;
                end
                ST_BURST: begin
                    if (burst_go) begin
                        ack_reg <= rd_valid;
                        err_reg <= ~rd_valid;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
            // Out-of-range reads keep the mux pointed at a real bank.
            if (rd_en && rd_valid) begin
                bank_sel_reg <= rd_bank;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
        logic [DATA_WIDTH-1:0] rd_data_reg;
        logic                  bank_we;

        assign bank_we = wr_en && (wr_bank == BANK_W'(gi));

        // Read and write share one process so a same-word read returns the old contents.
        always_ff @(posedge clk_i) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
                if (bank_we && wb.sel_i[b]) begin
                    mem[wr_row][8*b +: 8] <= wb.dat_i[8*b +: 8];
                end
            end
            if (rst_i) begin
                rd_data_reg <= '0;
            end else if (rd_en) begin
                rd_data_reg <= mem[rd_row];
            end
        end

        assign bank_rd_data[gi] = rd_data_reg;
    end

    assign wb.dat_o = bank_rd_data[bank_sel_reg];
    assign wb.ack_o = ack_reg;
    assign wb.err_o = err_reg;
endmodule
